hub75_framebuf: RTL

- Double-buffered pixel frame store that sits directly upstream of the HUB75 display scanner.
- Accepts a raster-order RGB pixel stream over a valid/ready handshake and writes it into the back bank.
- Serves registered, per-segment pixel reads to the scanner from the front bank.
- Swaps banks only when a full frame is stored and the scanner requests the swap at its frame boundary, so the panel never shows a torn frame.

---
 rtl/hub75_framebuf.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hub75_framebuf.sv
// Double-buffered HUB75 frame store: raster pixel stream in (back bank), registered per-segment reads out (front bank).
// Optional HUB75_FB_GAMMA_EN squares each channel ((c*c)>>BPP) on the write path.
module hub75_framebuf #(
  parameter int HPIXEL   = 64,
  parameter int VPIXEL   = 64,
  parameter int BPP      = 8,
  parameter int SEGMENTS = 2,
  localparam int FRAME    = HPIXEL * VPIXEL,
  localparam int SEG_SIZE = FRAME / SEGMENTS,
  localparam int RD_AW    = $clog2(FRAME),
  localparam int WR_AW    = $clog2(FRAME),
  localparam int PW       = 3 * BPP
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic                   s_sof,
  input  logic [PW-1:0]          s_data,
  input  logic [RD_AW-1:0]       i_rd_addr,
  output logic [SEGMENTS*PW-1:0] o_rd_data,
  input  logic                   i_swap_req,
  output logic                   o_front_bank,
  output logic                   o_frame_ready,
  output logic                   o_err_sof
);

  localparam int MEM_AW = $clog2(2 * SEG_SIZE);

  // Handshake: a beat transfers on a rising clk edge where s_valid && s_ready;
  // s_ready is registered from the FSM state and never depends on s_valid.
  typedef enum logic [1:0] {WAIT_SOF, FILL, FULL} state_t;

  state_t            state;
  logic [WR_AW-1:0]  ptr;
  logic              accept;
  logic              wr_en;
  logic [WR_AW-1:0]  wr_p;
  logic [PW-1:0]     wr_data;
  int                wr_seg;
  logic [MEM_AW-1:0] wr_idx;
  logic [MEM_AW-1:0] rd_idx;

`ifdef HUB75_FB_GAMMA_EN
  function automatic logic [PW-1:0] gamma(input logic [PW-1:0] v);
    logic [PW-1:0]      r;
    logic [BPP-1:0]     ch;
    logic [2*BPP-1:0]   sq;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      ch = v[c*BPP +: BPP];
      sq = {{BPP{1'b0}}, ch} * {{BPP{1'b0}}, ch};
      r[c*BPP +: BPP] = sq[2*BPP-1:BPP];
    end
    return r;
  endfunction
  assign wr_data = gamma(s_data);
`else
  assign wr_data = s_data;
`endif

  assign accept = s_valid && s_ready;
  // A start-of-frame beat always lands at pixel 0, in WAIT_SOF and mid-frame alike.
  assign wr_en  = accept && (s_sof || state == FILL);
  assign wr_p   = s_sof ? '0 : ptr;

  always_comb begin
    wr_seg = int'(wr_p) / SEG_SIZE;
    wr_idx = MEM_AW'(int'(!o_front_bank) * SEG_SIZE + int'(wr_p) % SEG_SIZE);
    rd_idx = MEM_AW'(int'(o_front_bank) * SEG_SIZE + int'(i_rd_addr) % SEG_SIZE);
  end

  for (genvar g = 0; g < SEGMENTS; g++) begin : g_seg
    logic [PW-1:0] mem [2*SEG_SIZE];
    logic [PW-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en && wr_seg == g) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= mem[rd_idx];
    end

    assign o_rd_data[g*PW +: PW] = rd_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= WAIT_SOF;
      ptr           <= '0;
      s_ready       <= 1'b0;
      o_front_bank  <= 1'b0;
      o_frame_ready <= 1'b0;
      o_err_sof     <= 1'b0;
    end else begin
      o_err_sof <= 1'b0;
      case (state)
        WAIT_SOF: begin
          s_ready <= 1'b1;
          if (accept && s_sof) begin
            ptr   <= WR_AW'(1);
            state <= FILL;
          end
        end
        FILL: begin
          s_ready <= 1'b1;
          if (accept) begin
            if (s_sof) begin
              ptr       <= WR_AW'(1);
              o_err_sof <= 1'b1;
            end else if (ptr == WR_AW'(FRAME - 1)) begin
              state         <= FULL;
              o_frame_ready <= 1'b1;
              s_ready       <= 1'b0;
            end else begin
              ptr <= ptr + WR_AW'(1);
            end
          end
        end
        FULL: begin
          s_ready <= 1'b0;
          if (i_swap_req) begin
            o_front_bank  <= ~o_front_bank;
            o_frame_ready <= 1'b0;
            ptr           <= '0;
            state         <= WAIT_SOF;
            s_ready       <= 1'b1;
          end
        end
        default: state <= WAIT_SOF;
      endcase
    end
  end

endmodule
